// File: rtl/integral_image_generator.sv
// Raster-order integral image generator: emits S(x,y) for every accepted pixel, one cycle after acceptance.
// Backpressure: a held word stalls pix_ready until consumed; pix_ready is low while the last word of a frame drains.
module integral_image_generator #(
    parameter int PIX_WIDTH = 8,
    parameter int WORD_SIZE = 32,
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 48
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [PIX_WIDTH-1:0] pix,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [WORD_SIZE-1:0] data,
    output logic                 data_ready,
    input  logic                 data_wanted,
    output logic                 frame_done
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        FIRST_ROW,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [WORD_SIZE-1:0] row_acc;
    logic [WORD_SIZE-1:0] line_buf [IMG_W];

    logic                 accept;
    logic                 consume;
    logic                 last_col;
    logic                 last_row;
    logic [WORD_SIZE-1:0] row_sum;
    logic [WORD_SIZE-1:0] above;
    logic [WORD_SIZE-1:0] sum;

    assign pix_ready  = (state != DRAIN) && (!data_ready || data_wanted);
    assign accept     = pix_valid && pix_ready;
    assign consume    = data_ready && data_wanted;
    assign last_col   = (x == XW'(IMG_W - 1));
    assign last_row   = (y == YW'(IMG_H - 1));
    assign frame_done = (state == DRAIN) && consume;

    // The line buffer is never reset; the first row of each frame masks it so stale sums cannot leak.
    assign row_sum = row_acc + WORD_SIZE'(pix);
    assign above   = (state == FIRST_ROW) ? '0 : line_buf[x];
    assign sum     = row_sum + above;

    always_comb begin
        state_nxt = state;
        case (state)
            FIRST_ROW: if (accept && last_col) state_nxt = (IMG_H == 1) ? DRAIN : RUN;
            RUN:       if (accept && last_col && last_row) state_nxt = DRAIN;
            DRAIN:     if (consume) state_nxt = FIRST_ROW;
            default:   state_nxt = FIRST_ROW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= FIRST_ROW;
            x          <= '0;
            y          <= '0;
            row_acc    <= '0;
            data       <= '0;
            data_ready <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data       <= sum;
                data_ready <= 1'b1;
                if (last_col) begin
                    x       <= '0;
                    row_acc <= '0;
                    y       <= last_row ? '0 : y + 1'b1;
                end else begin
                    x       <= x + 1'b1;
                    row_acc <= row_sum;
                end
            end else if (consume) begin
                data_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && resetn) line_buf[x] <= sum;
    end

endmodule

// File: tb/tb_integral_image_generator.sv
// Randomised scoreboard bench for integral_image_generator; expected words come from direct 2-D prefix sums.
module tb_integral_image_generator;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int BW = 64;
    localparam int BH = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [7:0]  pix;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] data;
    logic        data_ready;
    logic        data_wanted;
    logic        frame_done;

    logic [7:0]  b_pix;
    logic        b_valid;
    logic        b_want;
    logic        b_ready32, b_ready16;
    logic [31:0] b_data32;
    logic [15:0] b_data16;
    logic        b_dr32, b_dr16;
    logic        b_fd32, b_fd16;

    integral_image_generator #(.PIX_WIDTH(8), .WORD_SIZE(32), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .resetn(resetn), .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .data(data), .data_ready(data_ready), .data_wanted(data_wanted), .frame_done(frame_done)
    );

    integral_image_generator #(.PIX_WIDTH(8), .WORD_SIZE(32), .IMG_W(BW), .IMG_H(BH)) dut_big32 (
        .clk(clk), .resetn(resetn), .pix(b_pix), .pix_valid(b_valid), .pix_ready(b_ready32),
        .data(b_data32), .data_ready(b_dr32), .data_wanted(b_want), .frame_done(b_fd32)
    );

    integral_image_generator #(.PIX_WIDTH(8), .WORD_SIZE(16), .IMG_W(BW), .IMG_H(BH)) dut_big16 (
        .clk(clk), .resetn(resetn), .pix(b_pix), .pix_valid(b_valid), .pix_ready(b_ready16),
        .data(b_data16), .data_ready(b_dr16), .data_wanted(b_want), .frame_done(b_fd16)
    );

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int outstanding = 0;
    bit drain_m = 1'b0;

    logic [7:0]  tx_q[$];
    bit          tx_last_q[$];
    logic [31:0] exp_q[$];
    bit          exp_last_q[$];

    // Reference: S(x,y) is the plain sum of every pixel at or above-left of (x,y), modulo 2^32.
    task automatic queue_frame(input bit rnd, input logic [7:0] val);
        logic [7:0] p[N];
        longint s;
        for (int i = 0; i < N; i++) p[i] = rnd ? 8'($urandom_range(0, 255)) : val;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                s = 0;
                for (int j = 0; j <= yy; j++)
                    for (int i = 0; i <= xx; i++) s += p[j*W + i];
                tx_q.push_back(p[yy*W + xx]);
                tx_last_q.push_back(yy == H-1 && xx == W-1);
                exp_q.push_back(s[31:0]);
                exp_last_q.push_back(yy == H-1 && xx == W-1);
            end
        end
    endtask

    task automatic clear_model();
        tx_q.delete(); tx_last_q.delete(); exp_q.delete(); exp_last_q.delete();
        outstanding = 0;
        drain_m = 1'b0;
    endtask

    task automatic run_stream(input int want_mode, input int valid_mode, input int stop_after,
                              input int max_cycles, output int accepted);
        bit          prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        int          cyc = 0;
        accepted = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && (stop_after < 0 || accepted < stop_after)) begin
            if (cyc >= max_cycles) begin
                checks++; errors++;
                $display("FAIL stream_timeout: %0d pixels and %0d words still pending after %0d cycles",
                         tx_q.size(), exp_q.size(), cyc);
                break;
            end
            @(negedge clk);
            pix_valid = (tx_q.size() > 0) && (valid_mode == 0 || $urandom_range(0, 3) != 0);
            pix = pix_valid ? tx_q[0] : 8'($urandom);
            case (want_mode)
                0:       data_wanted = 1'b1;
                1:       data_wanted = (cyc % 2 == 0);
                default: data_wanted = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            checks++;
            if (data_ready !== (outstanding == 1)) begin
                errors++;
                $display("FAIL data_ready_state: got %b expected %b (cycle %0d)", data_ready, outstanding == 1, cyc);
            end
            if (prev_hold) begin
                checks++;
                if (data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_data: got %0d expected %0d", data, prev_data);
                end
            end
            if (data_ready && !data_wanted) begin
                checks++;
                if (pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_while_held: pix_ready %b expected 0", pix_ready);
                end
            end
            if (drain_m) begin
                checks++;
                if (pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_drain: pix_ready %b expected 0", pix_ready);
                end
            end
            if (data_ready === 1'b1 && data_wanted) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %0d with nothing expected", data);
                end else begin
                    if (data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL data: got %0d expected %0d", data, exp_q[0]);
                    end
                    checks++;
                    if (frame_done !== exp_last_q[0]) begin
                        errors++;
                        $display("FAIL frame_done_on_consume: got %b expected %b", frame_done, exp_last_q[0]);
                    end
                    if (exp_last_q[0]) begin
                        drain_m = 1'b0;
                        frames_seen++;
                    end
                    void'(exp_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
                outstanding--;
            end else begin
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_done_idle: got %b expected 0", frame_done);
                end
            end
            if (pix_valid && pix_ready === 1'b1) begin
                if (tx_last_q[0]) drain_m = 1'b1;
                void'(tx_q.pop_front());
                void'(tx_last_q.pop_front());
                outstanding++;
                accepted++;
            end
            prev_hold = data_ready && !data_wanted;
            prev_data = data;
            cyc++;
        end
        @(negedge clk);
        pix_valid   = 1'b0;
        data_wanted = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pix_valid = 1'b0; data_wanted = 1'b0; pix = '0;
        b_valid = 1'b0; b_want = 1'b0; b_pix = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
        checks++;
        if (data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", data); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b expected 1", pix_ready); end
        clear_model();
    endtask

    task automatic test_all_ones();
        int acc;
        int f0 = frames_seen;
        queue_frame(1'b0, 8'd1);
        run_stream(0, 0, -1, 200, acc);
        checks++;
        if (frames_seen - f0 != 1) begin errors++; $display("FAIL all_ones_frames: got %0d expected 1", frames_seen - f0); end
    endtask

    task automatic test_toggle_want();
        int acc;
        int f0 = frames_seen;
        queue_frame(1'b0, 8'd1);
        run_stream(1, 0, -1, 200, acc);
        checks++;
        if (frames_seen - f0 != 1) begin errors++; $display("FAIL toggle_frames: got %0d expected 1", frames_seen - f0); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int f0 = frames_seen;
        queue_frame(1'b0, 8'd1);
        queue_frame(1'b0, 8'd1);
        queue_frame(1'b0, 8'd2);
        run_stream(0, 0, -1, 400, acc);
        checks++;
        if (frames_seen - f0 != 3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", frames_seen - f0); end
    endtask

    task automatic test_random();
        int acc;
        int f0 = frames_seen;
        for (int i = 0; i < 4; i++) queue_frame(1'b1, 8'd0);
        run_stream(2, 1, -1, 1000, acc);
        checks++;
        if (frames_seen - f0 != 4) begin errors++; $display("FAIL random_frames: got %0d expected 4", frames_seen - f0); end
    endtask

    task automatic test_midframe_reset();
        int acc;
        int f0;
        queue_frame(1'b0, 8'd1);
        run_stream(0, 0, 5, 100, acc);
        checks++;
        if (acc != 5) begin errors++; $display("FAIL midframe_accepted: got %0d expected 5", acc); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL midframe_reset_data_ready: got %b expected 0", data_ready); end
        clear_model();
        f0 = frames_seen;
        queue_frame(1'b0, 8'd1);
        run_stream(0, 0, -1, 200, acc);
        checks++;
        if (frames_seen - f0 != 1) begin errors++; $display("FAIL midframe_frames: got %0d expected 1", frames_seen - f0); end
    endtask

    task automatic test_large_frame();
        int idx = 0;
        int cyc = 0;
        bit done = 1'b0;
        @(negedge clk);
        b_pix = 8'd255; b_valid = 1'b1; b_want = 1'b1;
        while (!done) begin
            if (cyc >= 4000) begin
                checks++; errors++;
                $display("FAIL large_timeout: only %0d words consumed", idx);
                break;
            end
            @(negedge clk);
            #1;
            if (b_dr32 === 1'b1 && b_want) begin
                if (idx == BW) begin
                    checks++;
                    if (b_data32 !== 32'd510) begin errors++; $display("FAIL large_row1_first: got %0d expected 510", b_data32); end
                end
                if (idx == BW*BH - 1) begin
                    checks++;
                    if (b_data32 !== 32'h000BF400) begin errors++; $display("FAIL large_last32: got %0d expected 783360", b_data32); end
                    checks++;
                    if (b_fd32 !== 1'b1) begin errors++; $display("FAIL large_done32: got %b expected 1", b_fd32); end
                    checks++;
                    if (b_data16 !== 16'd62464) begin errors++; $display("FAIL large_last16: got %0d expected 62464", b_data16); end
                    checks++;
                    if (b_fd16 !== 1'b1) begin errors++; $display("FAIL large_done16: got %b expected 1", b_fd16); end
                    done = 1'b1;
                end
                idx++;
            end
            cyc++;
        end
        b_valid = 1'b0;
        b_want  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_toggle_want();
        test_back_to_back();
        test_random();
        test_midframe_reset();
        test_all_ones();
        test_large_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
